// File: rtl/mac_seq_ctrl.sv
// Sequencer for an external multiply-accumulate unit: clears the MAC, streams N operand pairs, captures the sum.
// Optional feature: define MAC_SEQ_LEN_EN to add a run-time vector length input (len).
module mac_seq_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LEN    = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            abort,
`ifdef MAC_SEQ_LEN_EN
    input  logic [$clog2(VEC_LEN+1)-1:0]    len,
`endif
    input  logic                            op_valid,
    input  logic [DATA_WIDTH-1:0]           op_a,
    input  logic [DATA_WIDTH-1:0]           op_b,
    output logic                            op_ready,
    output logic                            mac_en,
    output logic                            mac_clr,
    output logic [DATA_WIDTH-1:0]           mac_a,
    output logic [DATA_WIDTH-1:0]           mac_b,
    input  logic [3*DATA_WIDTH-1:0]         mac_cout,
    output logic                            res_valid,
    output logic [3*DATA_WIDTH-1:0]         res_data,
    input  logic                            res_ready,
    output logic                            busy
);

    localparam int CW = $clog2(VEC_LEN + 1);
    localparam int RW = 3 * DATA_WIDTH;
    localparam logic [CW-1:0] VEC_LEN_C = CW'(VEC_LEN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_t;

    state_t          state_r, state_s, state_pre_s;
    logic [CW-1:0]   count_r, count_s, count_pre_s;
    logic [CW-1:0]   n_r, n_s;
    logic [CW-1:0]   req_len_s;
    logic [RW-1:0]   res_data_r, res_data_s;
    logic            accept_s;
    logic            abort_any_s;

`ifdef MAC_SEQ_LEN_EN
    // Zero or out-of-range requests fall back to the full vector length.
    function automatic logic [CW-1:0] resolve_len(input logic [CW-1:0] req);
        if ((req == {CW{1'b0}}) || (req > VEC_LEN_C)) begin
            return VEC_LEN_C;
        end else begin
            return req;
        end
    endfunction

    assign req_len_s = resolve_len(len);
`else
    assign req_len_s = VEC_LEN_C;
`endif

    // Outputs are decoded from the state register; only the operand path is combinational.
    assign op_ready    = (state_r == ACCUM);
    assign accept_s    = op_ready & op_valid;
    assign mac_en      = accept_s;
    assign mac_clr     = (state_r == CLEAR);
    assign mac_a       = op_ready ? op_a : {DATA_WIDTH{1'b0}};
    assign mac_b       = op_ready ? op_b : {DATA_WIDTH{1'b0}};
    assign res_valid   = (state_r == RESULT);
    assign res_data    = res_data_r;
    assign busy        = (state_r != IDLE);
    assign abort_any_s = abort & (state_r != IDLE);

    // Next-state, pair counter and result capture.
    always_comb begin
        state_pre_s = state_r;
        count_pre_s = count_r;
        n_s         = n_r;
        res_data_s  = res_data_r;
        case (state_r)
            IDLE: begin
                if (start && !abort) begin
                    state_pre_s = CLEAR;
                    n_s         = req_len_s;
                end else begin
                    state_pre_s = IDLE;
                end
            end
            CLEAR: begin
                count_pre_s = {CW{1'b0}};
                state_pre_s = ACCUM;
            end
            ACCUM: begin
                if (accept_s) begin
                    count_pre_s = count_r + CW'(1);
                    if (count_r == (n_r - CW'(1))) begin
                        state_pre_s = DRAIN;
                    end else begin
                        state_pre_s = ACCUM;
                    end
                end else begin
                    count_pre_s = count_r;
                end
            end
            DRAIN: begin
                // The MAC has absorbed the last pair by now, so Cout is final.
                res_data_s  = mac_cout;
                state_pre_s = RESULT;
            end
            RESULT: begin
                if (res_ready) begin
                    state_pre_s = IDLE;
                end else begin
                    state_pre_s = RESULT;
                end
            end
            default: begin
                state_pre_s = IDLE;
                count_pre_s = {CW{1'b0}};
            end
        endcase
        state_s = abort_any_s ? IDLE : state_pre_s;
        count_s = abort_any_s ? {CW{1'b0}} : count_pre_s;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            count_r    <= {CW{1'b0}};
            n_r        <= VEC_LEN_C;
            res_data_r <= {RW{1'b0}};
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            n_r        <= n_s;
            res_data_r <= res_data_s;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl with a behavioural MAC model and a result scoreboard.
module tb_mac_seq_ctrl;
    localparam int DW = 8;
    localparam int VL = 4;
    localparam int CW = $clog2(VL + 1);
    localparam int RW = 3 * DW;

    logic          clk, rst_n, start, abort, op_valid, res_ready;
    logic [DW-1:0] op_a, op_b, mac_a, mac_b;
    logic          op_ready, mac_en, mac_clr, res_valid, busy;
    logic [RW-1:0] mac_cout, res_data, acc;
`ifdef MAC_SEQ_LEN_EN
    logic [CW-1:0] len;
`endif

    mac_seq_ctrl #(.DATA_WIDTH(DW), .VEC_LEN(VL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef MAC_SEQ_LEN_EN
        .len(len),
`endif
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .mac_en(mac_en), .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b),
        .mac_cout(mac_cout), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External MAC: registered accumulator, Clr has priority over En.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else if (mac_clr) acc <= '0;
        else if (mac_en) acc <= acc + RW'(mac_a) * RW'(mac_b);
    end
    assign mac_cout = acc;

    int clr_cnt = 0;
    int en_cnt  = 0;
    always @(posedge clk) begin
        if (mac_clr) clr_cnt = clr_cnt + 1;
        if (mac_en)  en_cnt  = en_cnt + 1;
    end

    typedef struct {
        int              npairs;
        int              lenv;
        logic [3:0][7:0] a;
        logic [3:0][7:0] b;
        int              gap;
        int              rdly;
        logic [RW-1:0]   exp;
    } vec_t;

    vec_t          vecs[$];
    logic [RW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int np, input int ln, input logic [31:0] a,
                                input logic [31:0] b, input int gap, input int rdly,
                                input logic [RW-1:0] e);
        vec_t v;
        v.npairs = np; v.lenv = ln; v.a = a; v.b = b;
        v.gap = gap; v.rdly = rdly; v.exp = e;
        return v;
    endfunction

    // One complete dot product; ends right after the handshake cycle so calls chain back-to-back.
    task automatic run_vec(input vec_t v);
        logic [RW-1:0] held;
        int clr0, en0;
        held = '0;
        exp_q.push_back(v.exp);
        @(negedge clk);
        clr0 = clr_cnt; en0 = en_cnt;
        start = 1'b1; res_ready = 1'b0;
`ifdef MAC_SEQ_LEN_EN
        len = CW'(v.lenv);
`endif
        #1 chk("idle_busy", busy, 0);
        chk("idle_res_valid", res_valid, 0);
        @(negedge clk);
        start = 1'b0;
        #1 chk("clr_pulse", mac_clr, 1);
        chk("clr_no_en", mac_en, 0);
        for (int p = 0; p < v.npairs; p++) begin
            for (int g = 0; g < v.gap; g++) begin
                @(negedge clk);
                op_valid = 1'b0;
                #1 chk("stall_no_en", mac_en, 0);
                chk("accum_ready", op_ready, 1);
            end
            @(negedge clk);
            op_valid = 1'b1; op_a = v.a[p]; op_b = v.b[p];
            #1 chk("accept_en", mac_en, 1);
            chk("pass_a", mac_a, v.a[p]);
            chk("pass_b", mac_b, v.b[p]);
        end
        @(negedge clk);
        op_a = 8'hff; op_b = 8'hff;
        #1 chk("drain_ready", op_ready, 0);
        chk("drain_no_en", mac_en, 0);
        chk("drain_res_valid", res_valid, 0);
        for (int k = 0; k <= v.rdly; k++) begin
            @(negedge clk);
            op_valid = 1'b0;
            res_ready = (k == v.rdly);
            start = (k < v.rdly);
            #1 chk("res_valid", res_valid, 1);
            if (k == 0) held = res_data;
            else chk("res_hold", res_data, held);
            if (k == v.rdly) begin
                if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
                else chk("res_data", res_data, exp_q.pop_front());
            end
        end
        start = 1'b0;
        chk("clr_count", clr_cnt - clr0, 1);
        chk("en_count", en_cnt - en0, v.npairs);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; op_valid = 1'b0;
        op_a = '0; op_b = '0; res_ready = 1'b0;
`ifdef MAC_SEQ_LEN_EN
        len = '0;
`endif
        #7;
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back(mk(4, 4, {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, 0, 24'd100));
        vecs.push_back(mk(4, 4, {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 2, 0, 24'd100));
        vecs.push_back(mk(4, 4, {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, 3, 24'd100));
        vecs.push_back(mk(4, 4, 32'hffffffff, 32'hffffffff, 0, 0, 24'd260100));
        vecs.push_back(mk(4, 4, {8'd3, 8'd2, 8'd1, 8'd0}, {8'd3, 8'd2, 8'd1, 8'd0}, 1, 0, 24'd14));
`ifdef MAC_SEQ_LEN_EN
        vecs.push_back(mk(2, 2, {8'd0, 8'd0, 8'd5, 8'd3}, {8'd0, 8'd0, 8'd6, 8'd4}, 0, 0, 24'd42));
        vecs.push_back(mk(4, 0, {8'd7, 8'd5, 8'd3, 8'd1}, {8'd8, 8'd6, 8'd4, 8'd2}, 0, 0, 24'd100));
`endif
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("post_idle_busy", busy, 0);

        // Abort after two accepted pairs.
        @(negedge clk); start = 1'b1;
`ifdef MAC_SEQ_LEN_EN
        len = '0;
`endif
        @(negedge clk); start = 1'b0;
        @(negedge clk); op_valid = 1'b1; op_a = 8'd1; op_b = 8'd2;
        @(negedge clk); op_a = 8'd3; op_b = 8'd4;
        @(negedge clk); op_valid = 1'b0; abort = 1'b1;
        #1 chk("pre_abort_busy", busy, 1);
        @(negedge clk); abort = 1'b0;
        #1 chk("abort_busy", busy, 0);
        chk("abort_op_ready", op_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1 chk("abort_no_result", res_valid, 0);
        end
        run_vec(vecs[0]);

        // Asynchronous reset in the middle of ACCUM.
        @(negedge clk); res_ready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); op_valid = 1'b1; op_a = 8'd5; op_b = 8'd6;
        #1 chk("mid_accum_en", mac_en, 1);
        #2 rst_n = 1'b0;
        #1 chk("arst_busy", busy, 0);
        chk("arst_op_ready", op_ready, 0);
        chk("arst_mac_en", mac_en, 0);
        chk("arst_mac_clr", mac_clr, 0);
        chk("arst_res_valid", res_valid, 0);
        chk("arst_res_data", res_data, 0);
        @(negedge clk); op_valid = 1'b0; rst_n = 1'b1;
        run_vec(vecs[0]);
        @(negedge clk); res_ready = 1'b0;
        #1 chk("final_idle", busy, 0);
        if (exp_q.size() != 0) chk("scoreboard_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
